seq_detect_mealy: RTL and testbench
===================================

# seq_detect_mealy

Parametrised serial Mealy sequence detector: the generalised successor of the team's single-bit Mealy detector. Compares a serial bit stream against a compile-time pattern of configurable length, supports overlapping and non-overlapping match modes, a per-bit valid qualifier and a runtime clear. Counts matches in a saturating counter. Sits on a serial input stream, next to the front-end bit recovery. Its output `y` feeds downstream framing logic.

## Interface
- `W`, default 4: pattern length in bits. Legal range 2..16.
- `PATTERN`, default 4'b1011: pattern to detect, `W` bits wide. The first bit received is compared to `PATTERN[W-1]`.
- `OVERLAP`, default 1: 1 selects overlapping matches; 0 restarts detection after each match.
- `CNT_W`, default 8: width of the match counter.
- Ports:
  - `clk`  in  1  sole clock; all state updates on the rising edge.
  - `rst`  in  1  synchronous, active-high reset.
  - `x`  in  1  serial data bit.
  - `x_vld`  in  1  qualifies `x`; the bit is consumed only when high.
  - `clr`  in  1  synchronous clear of the detector state and the counter.
  - `y`  out  1  Mealy match output; combinational from `x`, `x_vld` and the registered state.
  - `match_cnt`  out  `CNT_W`  number of matches since reset or clear; saturates at its maximum.
  - `cnt_sat`  out  1  high while `match_cnt` equals 2^`CNT_W`-1.

## Operation
- State registers:
  - `hist[W-2:0]`: the last `W-1` consumed bits, newest in the LSB.
  - `fill`: number of consumed bits, saturating at `W-1`.
  - `match_cnt`.
- Match window is `{hist, x}`.
- `y = x_vld & (fill == W-1) & ({hist, x} == PATTERN) & ~rst & ~clr`.
- Cycle with `x_vld=1`, no `rst` or `clr`:
  - `hist <= {hist[W-3:0], x}`.
  - `fill <= min(fill+1, W-1)`.
  - Exception: when `y=1` and `OVERLAP=0`, set `fill <= 0`; `hist` content then becomes don't-care.
- Cycle with `x_vld=0`: state holds and `y=0`, regardless of `x`.
- `rst=1` or `clr=1` (both synchronous, identical effect):
  - `hist <= 0`, `fill <= 0`, `match_cnt <= 0`.
  - `y` is forced to 0 in that cycle.
  - `rst` has priority over everything; `clr` has priority over `x_vld`.
- Match counter:
  - `match_cnt <= match_cnt + 1` on each cycle with `y=1`, unless already at 2^`CNT_W`-1, where it holds.
  - Never wraps.
- Reset values: `y=0`, `match_cnt=0`, `cnt_sat=0`.
- `fill` gating prevents false matches on the zero-initialised `hist` (e.g. `PATTERN=4'b0001` must not fire on the first valid bit).

## Timing
- `y` has zero latency: it is high in the same cycle as the bit that completes the pattern.
- `match_cnt` and `cnt_sat` update one cycle after `y`.
- Minimum spacing between `y` pulses:
  - Overlap mode: 1 valid bit (e.g. `PATTERN=2'b11` on a run of ones).
  - Non-overlap mode: `W` valid bits.
- Gaps in `x_vld` of any length are transparent; only valid bits advance the state.
- `rst` or `clr` mid-pattern discards partial progress. The next match needs `W` fresh valid bits.

## Structure
- Shared package `seq_det_pkg`:
  - `W` and `CNT_W` range limits.
  - `fill` width function (`$clog2(W)`).
  - Default pattern constant.
- One sub-module: `sat_counter`, parametrised by width, with `rst`, `clr`, `inc` inputs and `cnt`, `sat` outputs. It implements `match_cnt` and `cnt_sat`.
- Detector window, fill logic and Mealy output stay in the top module.
- Elaboration-time check rejects `W<2`, `W>16` and `CNT_W<1`.

## Test plan
- Reset behaviour (defaults): hold `rst=1` while driving `x=1`, `x_vld=1` -> `y=0` every cycle; after release, `match_cnt=0`, `cnt_sat=0`.
- Overlap match (`W=4`, `PATTERN=1011`, `OVERLAP=1`): valid bits 1,0,1,1,0,1,1 -> `y` high on bits 4 and 7 only; `match_cnt=2`.
- Non-overlap match (`OVERLAP=0`): same stream 1,0,1,1,0,1,1 -> `y` high on bit 4 only; `match_cnt=1`. Appending 1,0,1,1 -> second `y` on the last of those bits.
- Valid gaps: valid 1,0, then 3 cycles `x_vld=0` with `x` toggling, then valid 1,1 -> `y` high exactly on the 4th valid bit, 0 during the gap.
- Saturation (`CNT_W=2`): 5 overlapped matches of `PATTERN=11` -> `match_cnt` = 1,2,3,3,3 and `cnt_sat=1` from the third match on. `clr` then returns both outputs to 0.
- Clear mid-pattern: valid 1,0,1, then `clr=1` with `x_vld=1`, `x=1` -> `y=0`. Then 1,0,1,1 -> `y` only on the final 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial Mealy sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

  // Legal range of the pattern length and minimum counter width.
  localparam int W_MIN     = 2;
  localparam int W_MAX     = 16;
  localparam int CNT_W_MIN = 1;

  // Default pattern for the 4-bit detector. The first received bit is the MSB.
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // Width of the fill counter. It must hold values 0..W-1.
  function automatic int fill_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
// Latency: cnt/sat update one cycle after inc.
// Backpressure: none; inc is accepted every cycle and ignored while saturated.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc -> cnt[WIDTH], sat
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign sat = (cnt_q == {WIDTH{1'b1}});
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rst || clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_detect_mealy.sv
// Serial Mealy detector for a W-bit pattern, with overlap/non-overlap modes and a match counter.
// Latency: y is combinational in the cycle of the completing bit; match_cnt/cnt_sat follow one cycle later.
// Backpressure: none; x is consumed on every cycle that x_vld is high, gaps hold state.
// Ports: clk, rst (sync, active-high), x, x_vld, clr (sync clear) -> y, match_cnt[CNT_W], cnt_sat
module seq_detect_mealy
  import seq_det_pkg::*;
#(
  parameter int             W       = 4,
  parameter logic [W-1:0]   PATTERN = W'(DEFAULT_PATTERN),
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_vld,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (W < W_MIN || W > W_MAX || CNT_W < CNT_W_MIN) begin : g_bad_params
    $error("seq_detect_mealy: illegal parameters W=%0d CNT_W=%0d", W, CNT_W);
  end

  localparam int                FILL_W   = fill_width(W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W - 1);

  logic [W-2:0]      hist_q;
  logic [W-2:0]      hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [W-1:0]      window;

  always_comb begin
    window = {hist_q, x};
    // Requiring a full history stops a zero-initialised hist from matching
    // patterns with leading zeros before W real bits have arrived.
    y      = x_vld & (fill_q == FILL_MAX) & (window == PATTERN) & ~rst & ~clr;
    hist_d = hist_q;
    fill_d = fill_q;
    if (rst || clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (x_vld) begin
      hist_d = window[W-2:0];
      if (y && !OVERLAP) begin
        // Restart detection; hist content is irrelevant until refilled.
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (y),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy across four parameter sets.
// Expected y values are queued when a bit is driven and popped when y is sampled.
// Counts are checked one cycle after the matching bit.
module tb_seq_detect_mealy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x_a   [4];
  logic vld_a [4];
  logic clr_a [4];
  logic y_a   [4];
  logic sat_a [4];
  logic [7:0] cnt_a [4];
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  // d0: default overlap 1011
  seq_detect_mealy #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_d0 (
    .clk(clk), .rst(rst), .x(x_a[0]), .x_vld(vld_a[0]), .clr(clr_a[0]),
    .y(y_a[0]), .match_cnt(cnt0), .cnt_sat(sat_a[0]));
  // d1: non-overlap 1011
  seq_detect_mealy #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .x(x_a[1]), .x_vld(vld_a[1]), .clr(clr_a[1]),
    .y(y_a[1]), .match_cnt(cnt1), .cnt_sat(sat_a[1]));
  // d2: 2-bit pattern 11, 2-bit counter
  seq_detect_mealy #(.W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .x(x_a[2]), .x_vld(vld_a[2]), .clr(clr_a[2]),
    .y(y_a[2]), .match_cnt(cnt2), .cnt_sat(sat_a[2]));
  // d3: leading-zero pattern 0001, exercises fill gating
  seq_detect_mealy #(.W(4), .PATTERN(4'b0001), .OVERLAP(1'b1), .CNT_W(8)) u_d3 (
    .clk(clk), .rst(rst), .x(x_a[3]), .x_vld(vld_a[3]), .clr(clr_a[3]),
    .y(y_a[3]), .match_cnt(cnt3), .cnt_sat(sat_a[3]));

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = {6'b0, cnt2};
  assign cnt_a[3] = cnt3;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    for (int i = 0; i < 4; i++) begin
      vld_a[i] = 1'b0;
      clr_a[i] = 1'b0;
    end
  endtask

  // Drive one cycle on DUT d, queue the expected y, sample y mid-cycle.
  task automatic step(input int d, input logic xb, input logic vb, input logic cb,
                      input bit ey, input string tag);
    @(posedge clk);
    #1;
    quiet_inputs();
    x_a[d]   = xb;
    vld_a[d] = vb;
    clr_a[d] = cb;
    exp_q.push_back(ey);
    #2;
    chk(tag, {7'b0, y_a[d]}, {7'b0, exp_q.pop_front()});
  endtask

  // Idle one cycle so the previous cycle's bit is committed, then check counters.
  task automatic cnt_chk(input int d, input logic [7:0] ec, input logic es, input string tag);
    @(posedge clk);
    #1;
    quiet_inputs();
    chk({tag, "_cnt"}, cnt_a[d], ec);
    chk({tag, "_sat"}, {7'b0, sat_a[d]}, {7'b0, es});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      x_a[i]   = 1'b1;
      vld_a[i] = 1'b1;
      clr_a[i] = 1'b0;
    end

    // Reset held with valid ones: y stays low everywhere.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #3;
      for (int i = 0; i < 4; i++) chk($sformatf("rst_y%0d", i), {7'b0, y_a[i]}, 8'h00);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet_inputs();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_cnt%0d", i), cnt_a[i], 8'h00);
      chk($sformatf("rst_sat%0d", i), {7'b0, sat_a[i]}, 8'h00);
    end

    // Overlap: 1011011 -> matches on bits 4 and 7.
    step(0, 1, 1, 0, 0, "ovl_b1"); step(0, 0, 1, 0, 0, "ovl_b2");
    step(0, 1, 1, 0, 0, "ovl_b3"); step(0, 1, 1, 0, 1, "ovl_b4");
    step(0, 0, 1, 0, 0, "ovl_b5"); step(0, 1, 1, 0, 0, "ovl_b6");
    step(0, 1, 1, 0, 1, "ovl_b7");
    cnt_chk(0, 8'd2, 1'b0, "ovl");

    // Non-overlap: same stream -> match on bit 4 only; then 1011 matches again.
    step(1, 1, 1, 0, 0, "nov_b1"); step(1, 0, 1, 0, 0, "nov_b2");
    step(1, 1, 1, 0, 0, "nov_b3"); step(1, 1, 1, 0, 1, "nov_b4");
    step(1, 0, 1, 0, 0, "nov_b5"); step(1, 1, 1, 0, 0, "nov_b6");
    step(1, 1, 1, 0, 0, "nov_b7");
    cnt_chk(1, 8'd1, 1'b0, "nov1");
    step(1, 1, 1, 0, 0, "nov_b8"); step(1, 0, 1, 0, 0, "nov_b9");
    step(1, 1, 1, 0, 0, "nov_b10"); step(1, 1, 1, 0, 1, "nov_b11");
    cnt_chk(1, 8'd2, 1'b0, "nov2");

    // Clear d0 with a valid 1 present, then valid gaps with toggling x.
    step(0, 1, 1, 1, 0, "gap_clr");
    cnt_chk(0, 8'd0, 1'b0, "gap_clr");
    step(0, 1, 1, 0, 0, "gap_v1"); step(0, 0, 1, 0, 0, "gap_v2");
    step(0, 1, 0, 0, 0, "gap_i1"); step(0, 0, 0, 0, 0, "gap_i2");
    step(0, 1, 0, 0, 0, "gap_i3");
    step(0, 1, 1, 0, 0, "gap_v3"); step(0, 1, 1, 0, 1, "gap_v4");
    cnt_chk(0, 8'd1, 1'b0, "gap");

    // Clear mid-pattern: 1,0,1 then clr on a bit that would otherwise complete 1011.
    step(0, 1, 1, 0, 0, "mid_b1"); step(0, 0, 1, 0, 0, "mid_b2");
    step(0, 1, 1, 0, 0, "mid_b3"); step(0, 1, 1, 1, 0, "mid_clr");
    step(0, 1, 1, 0, 0, "mid_b4"); step(0, 0, 1, 0, 0, "mid_b5");
    step(0, 1, 1, 0, 0, "mid_b6"); step(0, 1, 1, 0, 1, "mid_b7");
    cnt_chk(0, 8'd1, 1'b0, "mid");

    // Saturation: pattern 11, 2-bit counter.
    step(2, 1, 1, 0, 0, "sat_first");
    for (int m = 1; m <= 5; m++) begin
      step(2, 1, 1, 0, 1, $sformatf("sat_y%0d", m));
      cnt_chk(2, (m >= 3) ? 8'd3 : 8'(m), (m >= 3), $sformatf("sat_m%0d", m));
    end
    step(2, 0, 0, 1, 0, "sat_clr");
    cnt_chk(2, 8'd0, 1'b0, "sat_clr");

    // Fill gating: 0001 must not fire on the first valid bit.
    step(3, 1, 1, 0, 0, "fill_b1"); step(3, 0, 1, 0, 0, "fill_b2");
    step(3, 0, 1, 0, 0, "fill_b3"); step(3, 0, 1, 0, 0, "fill_b4");
    step(3, 1, 1, 0, 1, "fill_b5");
    cnt_chk(3, 8'd1, 1'b0, "fill");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
